serial_byte_receiver: RTL and testbench

- Receive end of the serial byte link. Recovers 8N1 asynchronous frames (idle high, 1 start bit, 8 data bits LSB first, 1 stop bit) from a single input line.
- Presents each received byte on data[7:0] with a one-cycle datavalid strobe. This is the same data/datavalid strobe convention our byte senders drive.
- Sits between the board serial pin and the encryptor core input. Its output must look to the core exactly like a local byte source.

---
 rtl/serial_byte_receiver_pkg.sv | 10 +
 rtl/serial_byte_receiver_if.sv | 10 +
 rtl/sync_2ff.sv | 15 +
 rtl/serial_byte_receiver.sv | 71 +++++++
 tb/tb_serial_byte_receiver.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/serial_byte_receiver_pkg.sv
// serial_byte_receiver_pkg: shared state encoding and defaults for the serial receive path
package rx_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t START = 3'd1;
    localparam state_t DATA  = 3'd2;
    localparam state_t STOP  = 3'd3;
    localparam state_t BREAK = 3'd4;
    localparam int DEFAULT_CLKS_PER_BIT = 868;
endpackage

// File: rtl/serial_byte_receiver_if.sv
// serial_byte_receiver_if: serial line in, byte strobe and status out
interface serial_byte_receiver_if;
    logic       rx;
    logic [7:0] data;
    logic       datavalid;
    logic       framing_err;
    logic       busy;
    modport master (output rx, input data, datavalid, framing_err, busy);
    modport slave  (input rx, output data, datavalid, framing_err, busy);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input pin
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    // shift the pin through two flops; reset to the line's idle level
    always_ff @(posedge clk)
        if (rst) {q, meta} <= {RST_VAL, RST_VAL};
        else     {q, meta} <= {meta, d};
endmodule

// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver: 8N1 frame recovery with one-cycle byte and framing-error strobes
module serial_byte_receiver
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input logic                  clk,
    input logic                  rst,
    serial_byte_receiver_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          rx_s;
    sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(bus.rx), .q(rx_s));
    assign bus.busy = state != IDLE;
    // frame FSM: half-bit to the start centre, then one full bit period per sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shift_reg       <= '0;
            bus.data        <= 8'h00;
            bus.datavalid   <= 1'b0;
            bus.framing_err <= 1'b0;
        end else begin
            bus.datavalid   <= 1'b0;
            bus.framing_err <= 1'b0;
            cnt             <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: if (cnt == HALF_LAST) begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= rx_s ? IDLE : DATA;
                end
                DATA: if (cnt == BIT_LAST) begin
                    cnt                <= '0;
                    shift_reg[bit_idx] <= rx_s;
                    if (bit_idx == 3'd7) state <= STOP;
                    else                 bit_idx <= bit_idx + 1'b1;
                end
                STOP: if (cnt == BIT_LAST) begin
                    cnt <= '0;
                    if (rx_s) begin
                        bus.data      <= shift_reg;
                        bus.datavalid <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        bus.framing_err <= 1'b1;
                        state           <= BREAK;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb_serial_byte_receiver: directed and random 8N1 frames checked against a frame-level model
module tb_serial_byte_receiver;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    serial_byte_receiver_if bus ();
    serial_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, failed = 0;
    logic [7:0] got_q[$], exp_q[$];
    int got_cyc[$], exp_cyc[$];
    logic got_busy[$];
    int fe_cnt = 0, exp_fe = 0, fe_cyc = 0;
    int overlap = 0, long_pulse = 0, drift = 0;
    logic prev_dv = 1'b0, prev_fe = 1'b0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // observe the DUT mid-cycle and log strobes
    always @(negedge clk) begin
        if (bus.datavalid) begin
            got_q.push_back(bus.data);
            got_cyc.push_back(cyc);
            got_busy.push_back(bus.busy);
        end
        if (bus.framing_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (bus.datavalid && bus.framing_err) overlap++;
        if ((bus.datavalid && prev_dv) || (bus.framing_err && prev_fe)) long_pulse++;
        if (!rst && !bus.datavalid && bus.data !== last_good) drift++;
        if (rst || bus.datavalid) last_good = bus.data;
        prev_dv = bus.datavalid;
        prev_fe = bus.framing_err;
    end

    // caller is at a negedge; returns at the negedge ending the stop bit
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        if (stop) begin
            exp_q.push_back(b);
            exp_cyc.push_back(cyc + LAT);
        end else exp_fe++;
        for (int i = 0; i < 10; i++) begin
            bus.rx = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_all(input string tag);
        check({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, " data"}, got_q[i], exp_q[i]);
            check({tag, " time"}, got_cyc[i], exp_cyc[i]);
            check({tag, " busy_at_dv"}, got_busy[i], 0);
        end
        check({tag, " fe_count"}, fe_cnt, exp_fe);
        got_q.delete(); exp_q.delete();
        got_cyc.delete(); exp_cyc.delete();
        got_busy.delete();
    endtask

    initial begin
        logic [9:0] f;
        int bh, dnz, lo, t0;
        logic [7:0] b;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst data", bus.data, 8'h00);
        check("rst datavalid", bus.datavalid, 0);
        check("rst framing_err", bus.framing_err, 0);
        check("rst busy", bus.busy, 0);
        rst = 1'b0;

        bh = 0; dnz = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.busy) bh++;
            if (bus.data !== 8'h00) dnz++;
        end
        check("idle busy", bh, 0);
        check("idle data", dnz, 0);
        compare_all("idle");

        send_frame(8'h40, 1'b1);
        idle(8);
        compare_all("single");

        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(8);
        compare_all("b2b");

        bus.rx = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch busy_high", bus.busy, 1);
        idle(20);
        check("glitch busy_low", bus.busy, 0);
        compare_all("glitch");

        t0 = cyc;
        send_frame(8'h55, 1'b0);
        lo = 0;
        repeat (100) begin
            @(negedge clk);
            if (!bus.busy) lo++;
        end
        check("break busy", lo, 0);
        check("break fe_time", fe_cyc, t0 + LAT);
        check("break data_held", bus.data, 8'h3C);
        idle(5);
        check("break release", bus.busy, 0);
        compare_all("break");

        f = {1'b1, 8'hFF, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = f[5];
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst data", bus.data, 8'h00);
        idle(2 * CPB);
        check("midrst busy", bus.busy, 0);
        compare_all("midrst");
        send_frame(8'h12, 1'b1);
        idle(8);
        compare_all("after_rst");

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.rx = 1'b0;
                repeat ($urandom_range(1, HALF - 2)) @(negedge clk);
                idle(CPB);
            end
            b = 8'($urandom);
            send_frame(b, 1'b1);
            idle($urandom_range(0, 3));
        end
        idle(20);
        compare_all("random");

        check("dv_fe_overlap", overlap, 0);
        check("pulse_width", long_pulse, 0);
        check("data_hold", drift, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
